// File: rtl/w_fetch_seq.sv
// -----------------------------------------------------------------------------
// w_fetch_seq
// Read-side sequencer for one neuron's weight memory. A start request walks
// read addresses 0..numWeight-1 through a memory with a one-cycle registered
// read, captures each returned word in a 2-entry buffer and streams the words
// in address order to the MAC over a valid/ready handshake. Reads are issued
// only while the buffer still has room for the word they will return, so MAC
// backpressure never drops or repeats a word.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a fetch pass (sampled only while idle)
//   busy       out  pass in progress (fetching or draining)
//   done       out  one-cycle pulse after the last weight is accepted
//   mem_ren    out  weight memory read enable
//   mem_radd   out  weight memory read address (holds when mem_ren=0)
//   mem_rdata  in   weight memory read data, valid the cycle after mem_ren
//   w_valid    out  w_data/w_idx/w_last hold a weight
//   w_ready    in   MAC accepts the current weight
//   w_data     out  weight word
//   w_idx      out  address of the current weight
//   w_last     out  current weight is the final one of the pass
// -----------------------------------------------------------------------------
module w_fetch_seq #(
  parameter int numWeight    = 10,
  parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_rdata,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [dataWidth-1:0]    w_data,
  output logic [addressWidth-1:0] w_idx,
  output logic                    w_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

  logic [1:0]              state_q, state_d;
  logic [addressWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [addressWidth-1:0] radd_q, radd_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              occ_q, occ_d;
  logic [dataWidth-1:0]    head_data_q, head_data_d;
  logic [addressWidth-1:0] head_idx_q, head_idx_d;
  logic                    head_last_q, head_last_d;
  logic [dataWidth-1:0]    tail_data_q, tail_data_d;
  logic [addressWidth-1:0] tail_idx_q, tail_idx_d;
  logic                    tail_last_q, tail_last_d;

  logic       pop_s;
  logic       push_s;
  logic       ren_s;
  logic       in_last_s;
  logic [2:0] used_s;

  // Handshake, capture and read-credit decode.
  always_comb begin
    pop_s     = (occ_q != 2'd0) && w_ready;
    push_s    = inflight_q;
    // radd_q always holds the address of the read now returning data.
    in_last_s = (radd_q == LAST_IDX);
    // Slots already claimed after this cycle's pop: buffered words plus the
    // word still coming back from memory. pop implies occ_q>=1, so no underflow.
    used_s    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    ren_s     = (state_q == S_FETCH) && (used_s < 3'd2);
  end

  // Sequencer state, read pointer and last-issued address.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    radd_d     = radd_q;
    inflight_d = ren_s;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          rd_ptr_d = {addressWidth{1'b0}};
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_FETCH: begin
        if (ren_s) begin
          rd_ptr_d = rd_ptr_q + addressWidth'(1);
          radd_d   = rd_ptr_q;
          if (rd_ptr_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (pop_s && head_last_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Two-entry buffer: head drives the outputs, tail holds the word that
  // arrived while the MAC was stalling.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_idx_d  = head_idx_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_idx_d  = tail_idx_q;
    tail_last_d = tail_last_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_data_d = mem_rdata;
          head_idx_d  = radd_q;
          head_last_d = in_last_s;
        end else begin
          tail_data_d = mem_rdata;
          tail_idx_d  = radd_q;
          tail_last_d = in_last_s;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_idx_d  = tail_idx_q;
        head_last_d = tail_last_q;
        occ_d       = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_data_d = mem_rdata;
          head_idx_d  = radd_q;
          head_last_d = in_last_s;
        end else begin
          head_data_d = tail_data_q;
          head_idx_d  = tail_idx_q;
          head_last_d = tail_last_q;
          tail_data_d = mem_rdata;
          tail_idx_d  = radd_q;
          tail_last_d = in_last_s;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // State registers; reset discards any word still returning from memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= {addressWidth{1'b0}};
      radd_q      <= {addressWidth{1'b0}};
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_data_q <= {dataWidth{1'b0}};
      head_idx_q  <= {addressWidth{1'b0}};
      head_last_q <= 1'b0;
      tail_data_q <= {dataWidth{1'b0}};
      tail_idx_q  <= {addressWidth{1'b0}};
      tail_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      radd_q      <= radd_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_idx_q  <= head_idx_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_idx_q  <= tail_idx_d;
      tail_last_q <= tail_last_d;
    end
  end

  // Output drive; the data outputs come straight from the head registers.
  always_comb begin
    busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
    mem_ren  = ren_s;
    mem_radd = ren_s ? rd_ptr_q : radd_q;
    w_valid  = (occ_q != 2'd0);
    w_data   = head_data_q;
    w_idx    = head_idx_q;
    w_last   = (occ_q != 2'd0) && head_last_q;
  end

endmodule

// File: tb/tb_w_fetch_seq.sv
module tb_w_fetch_seq;

  localparam int N  = 10;
  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, busy, done, mem_ren, w_valid, w_ready, w_last;
  logic [AW-1:0] mem_radd, w_idx;
  logic [DW-1:0] mem_rdata, w_data;

  logic          start1, busy1, done1, mem_ren1, w_valid1, w_ready1, w_last1;
  logic [0:0]    mem_radd1, w_idx1;
  logic [DW-1:0] mem_rdata1, w_data1;

  logic [DW-1:0] mem_base;

  int n_pass;
  int n_total;

  w_fetch_seq #(.numWeight(N), .dataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_rdata(mem_rdata),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
    .w_last(w_last)
  );

  w_fetch_seq #(.numWeight(1), .dataWidth(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mem_ren(mem_ren1), .mem_radd(mem_radd1), .mem_rdata(mem_rdata1),
    .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1), .w_idx(w_idx1),
    .w_last(w_last1)
  );

  // Weight memories with a one-cycle registered read: mem[i] = base + i.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_base + 16'(mem_radd);
    if (mem_ren1) mem_rdata1 <= 16'hA000 + 16'(mem_radd1);
  end

  // One full pass from start. mode: 0 ready high, 1 ready 1,0,0,1 repeating,
  // 2 random ready, 3 ready low for 20 cycles then high.
  // Reference: the k-th read must address k; the k-th accepted word must be
  // base+k with idx k; outstanding = reads issued - words accepted is at most 2.
  task automatic run_stream(input int mode, input bit hold_start,
                            output int done_cyc, output int first_valid_cyc);
    int exp_idx = 0;
    int reads = 0;
    int outstanding = 0;
    int cyc = 0;
    int last_hs_cyc = -10;
    bit got_done = 1'b0;
    bit pop;
    done_cyc = -1;
    first_valid_cyc = -1;
    start = 1'b1;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      cyc++;
      case (mode)
        0: w_ready = 1'b1;
        1: w_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        2: w_ready = 1'($urandom_range(0, 1));
        default: w_ready = (cyc > 20);
      endcase
      #1;
      pop = w_valid && w_ready;
      if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      n_total++;
      if (outstanding > 2) $display("FAIL overflow: outstanding %0d, max 2 (cyc %0d)", outstanding, cyc);
      else n_pass++;
      if (w_valid) begin
        n_total++;
        if (w_data !== mem_base + 16'(exp_idx) || w_idx !== 4'(exp_idx) || w_last !== (exp_idx == N - 1))
          $display("FAIL head: data %h idx %0d last %b, want %h %0d %b (cyc %0d)",
                   w_data, w_idx, w_last, mem_base + 16'(exp_idx), exp_idx, (exp_idx == N - 1), cyc);
        else n_pass++;
      end
      if (mem_ren) begin
        n_total++;
        if (mem_radd !== 4'(reads) || (outstanding - int'(pop)) >= 2 || reads >= N)
          $display("FAIL read_issue: radd %0d outstanding %0d pop %0d, want radd %0d, credit<2, reads<%0d",
                   mem_radd, outstanding, pop, reads, N);
        else n_pass++;
        reads++;
      end
      if (mode == 3 && cyc == 20) begin
        n_total++;
        if (reads !== 2 || mem_ren !== 1'b0 || w_valid !== 1'b1 || mem_radd !== 4'd1 || outstanding !== 2)
          $display("FAIL stall_state: reads %0d ren %b valid %b radd %0d buffered %0d, want 2 0 1 1 2",
                   reads, mem_ren, w_valid, mem_radd, outstanding);
        else n_pass++;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        n_total++;
        if (exp_idx !== N || last_hs_cyc !== cyc - 1 || reads !== N)
          $display("FAIL done_pulse: delivered %0d last_hs %0d reads %0d, want %0d %0d %0d",
                   exp_idx, last_hs_cyc, reads, N, cyc - 1, N);
        else n_pass++;
      end else begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL busy: got %b want 1 (cyc %0d)", busy, cyc);
        else n_pass++;
      end
      if (pop) begin
        exp_idx++;
        last_hs_cyc = cyc;
      end
      outstanding = outstanding + int'(mem_ren) - int'(pop);
    end
    n_total++;
    if (!got_done) $display("FAIL pass_timeout: no done within 200 cycles, delivered %0d of %0d", exp_idx, N);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; start1 = 1'b0; w_ready1 = 1'b0;
    mem_base = 16'hA000;
    #12;
    n_total++;
    if ({busy, done, mem_ren, mem_radd, w_valid, w_data, w_idx, w_last} !== '0 ||
        {busy1, done1, mem_ren1, mem_radd1, w_valid1, w_data1, w_idx1, w_last1} !== '0)
      $display("FAIL reset_outputs: dut %b/%b/%b/%h/%b/%h/%h/%b, want all 0",
               busy, done, mem_ren, mem_radd, w_valid, w_data, w_idx, w_last);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int dc, fv;
    @(negedge clk);
    mem_base = 16'hA000;
    run_stream(0, 1'b0, dc, fv);
    n_total++;
    if (fv !== 3 || dc !== N + 3) $display("FAIL basic_latency: first valid %0d done %0d, want 3 %0d", fv, dc, N + 3);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_idle: busy %b done %b, want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_ready_pattern;
    int dc, fv;
    @(negedge clk);
    run_stream(1, 1'b0, dc, fv);
  endtask

  task automatic test_stall;
    int dc, fv;
    @(negedge clk);
    run_stream(3, 1'b0, dc, fv);
  endtask

  task automatic test_start_held;
    int dc, fv;
    @(negedge clk);
    run_stream(0, 1'b1, dc, fv);
    @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || mem_ren !== 1'b0 || done !== 1'b0 || start !== 1'b1)
      $display("FAIL held_idle: busy %b ren %b done %b, want 0 0 0", busy, mem_ren, done);
    else n_pass++;
    run_stream(0, 1'b1, dc, fv);
    n_total++;
    if (fv !== 3) $display("FAIL held_second: first valid %0d, want 3", fv);
    else n_pass++;
    start = 1'b0;
  endtask

  task automatic test_reset_mid_pass;
    int dc, fv;
    @(negedge clk);
    w_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, mem_ren, mem_radd, w_valid, w_data, w_idx, w_last} !== '0)
      $display("FAIL reset_mid: busy %b done %b ren %b radd %h valid %b data %h idx %h last %b, want all 0",
               busy, done, mem_ren, mem_radd, w_valid, w_data, w_idx, w_last);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (w_valid !== 1'b0 || done !== 1'b0) $display("FAIL reset_stale: valid %b done %b, want 0 0", w_valid, done);
    else n_pass++;
    run_stream(0, 1'b0, dc, fv);
  endtask

  task automatic test_random;
    int dc, fv;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      mem_base = 16'($urandom);
      run_stream(2, 1'b0, dc, fv);
    end
    mem_base = 16'hA000;
  endtask

  task automatic test_single_weight;
    int reads = 0;
    int seen = 0;
    bit got_done = 1'b0;
    @(negedge clk);
    w_ready1 = 1'b1;
    start1 = 1'b1;
    for (int c = 1; c <= 20 && !got_done; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      if (mem_ren1) reads++;
      if (w_valid1) begin
        seen++;
        n_total++;
        if (c !== 3 || w_data1 !== 16'hA000 || w_idx1 !== 1'b0 || w_last1 !== 1'b1)
          $display("FAIL single_word: cyc %0d data %h idx %0d last %b, want 3 a000 0 1", c, w_data1, w_idx1, w_last1);
        else n_pass++;
      end
      if (done1) begin
        got_done = 1'b1;
        n_total++;
        if (c !== 4 || seen !== 1 || reads !== 1)
          $display("FAIL single_done: cyc %0d words %0d reads %0d, want 4 1 1", c, seen, reads);
        else n_pass++;
      end
    end
    n_total++;
    if (!got_done) $display("FAIL single_timeout: no done, words %0d", seen);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_ready_pattern();
    test_stall();
    test_start_held();
    test_reset_mid_pass();
    test_random();
    test_single_weight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
